alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between NUM_REQ requesters, for example the execute stage and the branch-target/address-generation path.
- Each requester uses a valid/ready request channel. Grants are round-robin.
- The ALU result is captured in a one-entry output register. It is returned on a shared response channel tagged with the requester id, and that channel supports backpressure.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- XLEN, 32, operand and result width.
- ID_W, $clog2(NUM_REQ) with minimum 1, width of the response tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  NUM_REQ x ALU_operation_t  per-requester ALU operation.
- req_a  in  NUM_REQ x XLEN  per-requester operand A.
- req_b  in  NUM_REQ x XLEN  per-requester operand B.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  XLEN  registered ALU result.
- rsp_zero  out  1  registered ALU zero flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rr_ptr=0.
  - req_ready is combinational and is 0 while rst_n=0.
- Two states, tracked by rsp_valid:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_accept = !rsp_valid || rsp_ready.
  - A response drain and a new accept in the same cycle give full throughput: one operation per cycle.
- Grant:
  - If can_accept and any req_valid is set, grant the first requester with valid set, searching from rr_ptr upward with wrap at NUM_REQ.
  - req_ready[g]=1 only for the granted index g; all other bits are 0.
  - If can_accept=0, req_ready is all zeros.
  - req_ready may depend combinationally on req_valid and rsp_ready. It must not depend on req_op, req_a or req_b.
- The ALU's operation, A and B inputs are muxed from the granted requester. With no grant, requester 0 is selected; this is don't-care.
- Accept (req_valid[g] && req_ready[g]) at edge N:
  - rsp_result/rsp_zero take the ALU outputs.
  - rsp_id takes g.
  - rsp_valid=1 after edge N, so latency is 1 cycle.
  - rr_ptr takes (g+1) mod NUM_REQ.
- Drain without a new accept (rsp_valid && rsp_ready, no grant): rsp_valid goes to 0. rsp_id and rsp_result hold their old values.
- Backpressure:
  - While rsp_valid=1 and rsp_ready=0, rsp_id, rsp_result and rsp_zero are stable.
  - No request is accepted in that state.
- rr_ptr changes only on accept. A requester that is not granted must keep its request stable; this is a requester obligation and is not checked by the block.
- Arithmetic and the zero flag are exactly those of ALU for every ALU_operation_t value. Shift amount is B[4:0].
- Reset asserted mid-operation: all state clears immediately and any pending response is lost. After release, arbitration restarts at index 0.

Decomposition:
- ALU_operation_t stays in the shared enum package and is reused unchanged.
- Add a localparam for the NUM_REQ limit to that package.
- Instantiate the existing ALU module unchanged.
- One sub-module is natural: rr_arbiter.
  - Parameter N.
  - Inputs: req[N], ptr[ID_W], en.
  - Outputs: gnt[N] one-hot, gnt_idx, any.
  - Purely combinational.
  - The rr_ptr register stays in alu_share_arbiter.

Test Plan:
- Reset: hold rst_n=0 with req_valid=2'b11 -> req_ready=0, rsp_valid=0, rsp_result=0. Release rst_n with req_valid=2'b11 -> requester 0 is granted first.
- Single op: req0 add 15,20 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=35, rsp_zero=0. Follow with sub 10,10 -> result 0, rsp_zero=1.
- Round-robin: both requesters valid every cycle; req0 sraALU 0x80000000,2 and req1 sltALU -5,2 -> accepts alternate 0,1,0,1; responses are 0xE0000000 (id 0) and 1 (id 1); one response per cycle.
- Backpressure: rsp_ready=0 for 3 cycles after the first accept -> req_ready=0 throughout and response fields stable. rsp_ready=1 -> drain and the next accept happen in the same cycle.
- Wrap and skip (NUM_REQ=3): only req2 valid, with rr_ptr=0 -> req2 granted, rr_ptr wraps to 0. Then req0 and req1 both valid -> req0 granted.
- Mid-op reset: assert rst_n low while rsp_valid=1 with sltuALU -5,2 pending (result 0) -> rsp_valid drops immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter.
//   ALU_operation_t : operation encoding understood by the shared ALU.
//   NUM_REQ_MIN/MAX : supported range of requester counts.
//   rsp_state_t     : occupancy of the one-entry response register.
//   id_width()      : tag width for a requester count (never below 1).
package alu_share_arbiter_pkg;

    typedef enum logic [3:0] {
        addALU,
        subALU,
        andALU,
        orALU,
        xorALU,
        sllALU,
        srlALU,
        sraALU,
        sltALU,
        sltuALU
    } ALU_operation_t;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

    typedef enum logic {
        EMPTY,
        FULL
    } rsp_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the arbiter.
//   req_valid/req_ready/req_op/req_a/req_b : per-requester request channels.
//   rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_zero : shared response channel.
// master: requester/consumer side.  slave: the arbiter.
interface alu_share_arbiter_if
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int ID_W    = id_width(NUM_REQ)
) ();

    logic           [NUM_REQ-1:0]           req_valid;
    logic           [NUM_REQ-1:0]           req_ready;
    ALU_operation_t [NUM_REQ-1:0]           req_op;
    logic           [NUM_REQ-1:0][XLEN-1:0] req_a;
    logic           [NUM_REQ-1:0][XLEN-1:0] req_b;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU shared by the requesters.
//   op     : operation select
//   a, b   : operands (shift amount is b[4:0])
//   result : operation result
//   zero   : result is all zeros
module alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  ALU_operation_t  op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        unique case (op)
            addALU:  result = a + b;
            subALU:  result = a - b;
            andALU:  result = a & b;
            orALU:   result = a | b;
            xorALU:  result = a ^ b;
            sllALU:  result = a << shamt;
            srlALU:  result = a >> shamt;
            sraALU:  result = $signed(a) >>> shamt;
            sltALU:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            sltuALU: result = {{(XLEN-1){1'b0}}, a < b};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority index (search starts here, wraps at N)
//   en      : grant allowed this cycle
//   gnt     : one-hot grant (zero when nothing granted)
//   gnt_idx : index of the grant (0 when nothing granted)
//   any     : a grant was issued
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    always_comb begin
        logic [ID_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        if (en) begin
            for (int unsigned i = 0; i < N; i++) begin
                idx = ID_W'((32'(ptr) + i) % N);
                if (!any && req[idx]) begin
                    any      = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_idx  = idx;
                end
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin
// grants and a one-entry, backpressurable response register.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request channels in, tagged response channel out (slave side)
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("alu_share_arbiter: NUM_REQ out of supported range");
    end

    rsp_state_t      state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rsp_id_q;
    logic [XLEN-1:0] rsp_result_q;
    logic            rsp_zero_q;

    logic               can_accept;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               accept;

    ALU_operation_t  alu_op;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic            alu_zero;

    // Draining and refilling in the same cycle keeps one op per cycle.
    assign can_accept = (state == EMPTY) || bus.rsp_ready;

    // rst_n gates the grant so req_ready is low throughout reset.
    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .en      (can_accept && rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (accept)
    );

    assign bus.req_ready = gnt;

    // gnt_idx is 0 without a grant, so requester 0 drives the idle ALU.
    assign alu_op = bus.req_op[gnt_idx];
    assign alu_a  = bus.req_a[gnt_idx];
    assign alu_b  = bus.req_b[gnt_idx];

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL: begin
                if (accept)             state_nxt = FULL;
                else if (bus.rsp_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        bus.rsp_valid = (state == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else if (accept) begin
            rr_ptr       <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            rsp_id_q     <= gnt_idx;
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
        end
    end

    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;

endmodule
